// File: rtl/cpu_pkg.sv
// Shared types for the pipeline bypass network: word/index types, tracking slot, forward select.
package cpu_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int CPU_REG_BITS = 5;

  typedef logic [CPU_WIDTH-1:0]    word_t;
  typedef logic [CPU_REG_BITS-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     is_load;
    reg_idx_t src_a;
    reg_idx_t src_b;
    logic     lit_b;
  } track_slot_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_P4 = 2'd1,
    FWD_P5 = 2'd2,
    FWD_P6 = 2'd3
  } fwd_sel_t;

  localparam track_slot_t SLOT_EMPTY = '0;

  // A slot only produces a forwardable result if it is live and writes a real register.
  function automatic logic slot_hits(input track_slot_t s, input reg_idx_t idx);
    return s.valid && (s.dest != '0) && (s.dest == idx);
  endfunction

endpackage

// File: rtl/cpu_fwd_mux.sv
// Per-operand forward select: youngest matching in-flight producer wins, else regfile data.
module cpu_fwd_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  reg_idx_t          i_src,
  input  logic              i_en,
  input  track_slot_t       i_p4,
  input  track_slot_t       i_p5,
  input  track_slot_t       i_p6,
  input  logic [WIDTH-1:0]  i_p4_result,
  input  logic [WIDTH-1:0]  i_p5_result,
  input  logic [WIDTH-1:0]  i_p6_latch,
  input  logic [WIDTH-1:0]  i_rf_data,
  output fwd_sel_t          o_sel,
  output logic [WIDTH-1:0]  o_data
);

  always_comb begin
    o_sel  = FWD_RF;
    o_data = i_rf_data;
    if (i_en && (i_src != '0)) begin
      if (slot_hits(i_p4, i_src)) begin
        o_sel  = FWD_P4;
        o_data = i_p4_result;
      end else if (slot_hits(i_p5, i_src)) begin
        o_sel  = FWD_P5;
        o_data = i_p5_result;
      end else if (slot_hits(i_p6, i_src)) begin
        o_sel  = FWD_P6;
        o_data = i_p6_latch;
      end
    end
  end

endmodule

// File: rtl/cpu_bypass.sv
// Operand forwarding into p3 and one-cycle load-use interlock at p2 for the 5-stage pipeline.
// Optional perf counters built when CPU_BYPASS_COUNT_EN is defined; otherwise tied to zero.
module cpu_bypass
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p2_valid,
  input  logic [REG_BITS-1:0] p2_reg_a,
  input  logic [REG_BITS-1:0] p2_reg_b,
  input  logic                p2_literal_b,
  input  logic [REG_BITS-1:0] p2_dest_reg,
  input  logic                p2_is_load,
  input  logic [WIDTH-1:0]    p3_data_a,
  input  logic [WIDTH-1:0]    p3_data_b,
  input  logic [WIDTH-1:0]    p4_result,
  input  logic [WIDTH-1:0]    p5_result,
  output logic                p2_stall,
  output logic [WIDTH-1:0]    p3_op_a,
  output logic [WIDTH-1:0]    p3_op_b,
  output logic [31:0]         fwd_count,
  output logic [31:0]         stall_count
);

  track_slot_t      w_p2_slot;
  track_slot_t      w_p3_next;
  track_slot_t      r_p3, r_p4, r_p5, r_p6;
  logic [WIDTH-1:0] r_p6_latch;
  logic             w_stall;
  fwd_sel_t         w_sel_a, w_sel_b;

  always_comb begin
    w_p2_slot         = SLOT_EMPTY;
    w_p2_slot.valid   = p2_valid;
    w_p2_slot.dest    = p2_dest_reg;
    w_p2_slot.is_load = p2_is_load;
    w_p2_slot.src_a   = p2_reg_a;
    w_p2_slot.src_b   = p2_reg_b;
    w_p2_slot.lit_b   = p2_literal_b;
  end

  // A load in p3 has no data until p5; a dependent p2 waits one cycle so it meets it there.
  always_comb begin
    w_stall = p2_valid && r_p3.valid && r_p3.is_load && (r_p3.dest != '0) &&
              ((r_p3.dest == p2_reg_a) || (!p2_literal_b && (r_p3.dest == p2_reg_b)));
  end

  assign w_p3_next = w_stall ? SLOT_EMPTY : w_p2_slot;
  assign p2_stall  = w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p3       <= SLOT_EMPTY;
      r_p4       <= SLOT_EMPTY;
      r_p5       <= SLOT_EMPTY;
      r_p6       <= SLOT_EMPTY;
      r_p6_latch <= '0;
    end else begin
      r_p3       <= w_p3_next;
      r_p4       <= r_p3;
      r_p5       <= r_p4;
      r_p6       <= r_p5;
      r_p6_latch <= p5_result;
    end
  end

  cpu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .i_src       (r_p3.src_a),
    .i_en        (1'b1),
    .i_p4        (r_p4),
    .i_p5        (r_p5),
    .i_p6        (r_p6),
    .i_p4_result (p4_result),
    .i_p5_result (p5_result),
    .i_p6_latch  (r_p6_latch),
    .i_rf_data   (p3_data_a),
    .o_sel       (w_sel_a),
    .o_data      (p3_op_a)
  );

  cpu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .i_src       (r_p3.src_b),
    .i_en        (!r_p3.lit_b),
    .i_p4        (r_p4),
    .i_p5        (r_p5),
    .i_p6        (r_p6),
    .i_p4_result (p4_result),
    .i_p5_result (p5_result),
    .i_p6_latch  (r_p6_latch),
    .i_rf_data   (p3_data_b),
    .o_sel       (w_sel_b),
    .o_data      (p3_op_b)
  );

`ifdef CPU_BYPASS_COUNT_EN
  logic [31:0] r_fwd_count, r_stall_count;
  logic [1:0]  w_fwd_inc;

  assign w_fwd_inc = {1'b0, r_p3.valid && (w_sel_a != FWD_RF)} +
                     {1'b0, r_p3.valid && (w_sel_b != FWD_RF)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fwd_count   <= '0;
      r_stall_count <= '0;
    end else begin
      r_fwd_count   <= r_fwd_count + {30'd0, w_fwd_inc};
      r_stall_count <= r_stall_count + {31'd0, w_stall};
    end
  end

  assign fwd_count   = r_fwd_count;
  assign stall_count = r_stall_count;
`else
  assign fwd_count   = '0;
  assign stall_count = '0;
`endif

`ifndef SYNTHESIS
  // The interlock guarantees a live p3 consumer never needs a load result from p4.
  a_no_p4_load_fwd : assert property (@(posedge clock) disable iff (reset)
    !(r_p3.valid && r_p4.is_load && ((w_sel_a == FWD_P4) || (w_sel_b == FWD_P4))));
`endif

endmodule

// File: tb/tb_cpu_bypass.sv
// Directed bench for cpu_bypass: forwarding distances, load-use stall, literal/r0, reset.
module tb_cpu_bypass;

  localparam logic [31:0] BAD4 = 32'hBAD4_BAD4;
  localparam logic [31:0] BAD5 = 32'hBAD5_BAD5;
  localparam logic [31:0] DEAD = 32'hDEAD_DEAD;

  logic        clock = 1'b0;
  logic        reset;
  logic        p2_valid;
  logic [4:0]  p2_reg_a, p2_reg_b, p2_dest_reg;
  logic        p2_literal_b, p2_is_load;
  logic [31:0] p3_data_a, p3_data_b, p4_result, p5_result;
  logic        p2_stall;
  logic [31:0] p3_op_a, p3_op_b, fwd_count, stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cpu_bypass #(.WIDTH(32), .REG_BITS(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .p2_valid     (p2_valid),
    .p2_reg_a     (p2_reg_a),
    .p2_reg_b     (p2_reg_b),
    .p2_literal_b (p2_literal_b),
    .p2_dest_reg  (p2_dest_reg),
    .p2_is_load   (p2_is_load),
    .p3_data_a    (p3_data_a),
    .p3_data_b    (p3_data_b),
    .p4_result    (p4_result),
    .p5_result    (p5_result),
    .p2_stall     (p2_stall),
    .p3_op_a      (p3_op_a),
    .p3_op_b      (p3_op_b),
    .fwd_count    (fwd_count),
    .stall_count  (stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_p2(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic lit, input logic [4:0] d, input logic ld);
    p2_valid     = v;
    p2_reg_a     = a;
    p2_reg_b     = b;
    p2_literal_b = lit;
    p2_dest_reg  = d;
    p2_is_load   = ld;
  endtask

  task automatic set_data(input logic [31:0] rfa, input logic [31:0] rfb,
                          input logic [31:0] r4, input logic [31:0] r5);
    p3_data_a = rfa;
    p3_data_b = rfb;
    p4_result = r4;
    p5_result = r5;
  endtask

  task automatic idle();
    drive_p2(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic flush();
    idle();
    set_data(DEAD, DEAD, BAD4, BAD5);
    repeat (5) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_data(32'h11, 32'h22, BAD4, BAD5);
    #12;
    check_eq("rst_stall", {31'd0, p2_stall}, 32'd0);
    check_eq("rst_op_a", p3_op_a, 32'h11);
    check_eq("rst_op_b", p3_op_b, 32'h22);
    check_eq("rst_fwd_cnt", fwd_count, 32'd0);
    check_eq("rst_stall_cnt", stall_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    flush();

    // 1: r1=5 then r2=r1+r0 one cycle later -> p4 result
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b0);
    tick();
    drive_p2(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b0);
    settle();
    check_eq("t1_no_stall", {31'd0, p2_stall}, 32'd0);
    tick();
    idle();
    set_data(DEAD, 32'd0, 32'd5, BAD5);
    settle();
    check_eq("t1_op_a_p4", p3_op_a, 32'd5);
    check_eq("t1_op_b_r0", p3_op_b, 32'd0);
    flush();

    // 2a: reader two cycles behind writer -> p5 result
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b0);
    tick();
    idle();
    tick();
    drive_p2(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b0);
    tick();
    idle();
    set_data(DEAD, 32'd0, BAD4, 32'h1234);
    settle();
    check_eq("t2_gap2_p5", p3_op_a, 32'h1234);
    flush();

    // 2b: three cycles behind -> p6 latch
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b0);
    tick();
    idle();
    tick();
    tick();
    set_data(DEAD, 32'd0, BAD4, 32'h1234);
    drive_p2(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b0);
    tick();
    idle();
    set_data(DEAD, 32'd0, BAD4, BAD5);
    settle();
    check_eq("t2_gap3_p6", p3_op_a, 32'h1234);
    flush();

    // 2c: four cycles behind -> regfile already holds the value
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b0);
    tick();
    idle();
    tick();
    tick();
    set_data(DEAD, 32'd0, BAD4, 32'h1234);
    tick();
    set_data(DEAD, 32'd0, BAD4, BAD5);
    drive_p2(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b0);
    tick();
    idle();
    set_data(32'h1234, 32'd0, BAD4, BAD5);
    settle();
    check_eq("t2_gap4_rf", p3_op_a, 32'h1234);
    flush();

    // 3: load r4 then r5=r4+r0 -> one stall, then forwarded from p5
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    drive_p2(1'b1, 5'd4, 5'd0, 1'b0, 5'd5, 1'b0);
    settle();
    check_eq("t3_stall_on", {31'd0, p2_stall}, 32'd1);
    tick();
    settle();
    check_eq("t3_stall_off", {31'd0, p2_stall}, 32'd0);
    tick();
    idle();
    set_data(DEAD, 32'd0, BAD4, 32'hCAFE);
    settle();
    check_eq("t3_op_a_load", p3_op_a, 32'hCAFE);
    flush();

    // 4a: r0 is never forwarded even if something "writes" it
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b0);
    tick();
    idle();
    set_data(32'd0, 32'd0, 32'd7, BAD5);
    settle();
    check_eq("t4_r0_op_a", p3_op_a, 32'd0);
    flush();

    // 4b: literal B neither stalls on nor forwards from a matching load
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1);
    tick();
    drive_p2(1'b1, 5'd0, 5'd2, 1'b0, 5'd8, 1'b0);
    settle();
    check_eq("t4_reg_b_stall", {31'd0, p2_stall}, 32'd1);
    drive_p2(1'b1, 5'd0, 5'd2, 1'b1, 5'd8, 1'b0);
    settle();
    check_eq("t4_lit_b_no_stall", {31'd0, p2_stall}, 32'd0);
    tick();
    idle();
    set_data(32'd0, 32'd9, BAD4, BAD5);
    settle();
    check_eq("t4_lit_b_op_b", p3_op_b, 32'd9);
    flush();

    // 5: r6=1, r6=2, read r6 on both operands -> youngest (p4) wins
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b0);
    tick();
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b0);
    tick();
    drive_p2(1'b1, 5'd6, 5'd6, 1'b0, 5'd9, 1'b0);
    tick();
    idle();
    set_data(DEAD, 32'hBEEF, 32'd2, 32'd1);
    settle();
    check_eq("t5_op_a_young", p3_op_a, 32'd2);
    check_eq("t5_op_b_young", p3_op_b, 32'd2);
    flush();

`ifdef CPU_BYPASS_COUNT_EN
    check_eq("cnt_fwd_total", fwd_count, 32'd6);
    check_eq("cnt_stall_total", stall_count, 32'd1);
`endif

    // 6: reset during a load-use stall clears everything at once
    drive_p2(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    drive_p2(1'b1, 5'd4, 5'd0, 1'b0, 5'd5, 1'b0);
    settle();
    check_eq("t6_stall_before", {31'd0, p2_stall}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_stall_reset", {31'd0, p2_stall}, 32'd0);
    check_eq("t6_fwd_cnt", fwd_count, 32'd0);
    check_eq("t6_stall_cnt", stall_count, 32'd0);
    set_data(32'h600D, 32'h700D, BAD4, BAD5);
    #1;
    check_eq("t6_op_a_rf", p3_op_a, 32'h600D);
    check_eq("t6_op_b_rf", p3_op_b, 32'h700D);
    @(negedge clock);
    reset = 1'b0;
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
